// File: rtl/beep_note_pkg.sv
// -----------------------------------------------------------------------------
// beep_note_pkg
// Shared definitions for the buzzer scale generator and its receive-side
// note detector.
//   * 3-bit note codes (0 = none, 1..7 = Do..Xi)
//   * nominal half-period counts of each note at 50 MHz
//   * classification window bounds (midpoints between nominal periods)
//   * detector FSM state type
//   * classifyPeriod(): maps a measured period onto a note code
// -----------------------------------------------------------------------------
package beep_note_pkg;

  // Note codes, identical to the generator's encoding
  localparam logic [2:0] NOTE_IDLE = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RI   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SO   = 3'd5;
  localparam logic [2:0] NOTE_LA   = 3'd6;
  localparam logic [2:0] NOTE_XI   = 3'd7;

  // Nominal half-period counts; a full period is twice these values
  localparam logic [31:0] HALF_DO = 32'd95419;
  localparam logic [31:0] HALF_RI = 32'd85034;
  localparam logic [31:0] HALF_MI = 32'd75757;
  localparam logic [31:0] HALF_FA = 32'd71633;
  localparam logic [31:0] HALF_SO = 32'd63775;
  localparam logic [31:0] HALF_LA = 32'd56818;
  localparam logic [31:0] HALF_XI = 32'd50607;

  // The midpoint between two neighbouring full periods (2*Ha + 2*Hb)/2 is
  // simply Ha + Hb. The two outer bounds have no neighbour in the scale and
  // are fixed values.
  localparam logic [31:0] WIN_DO_HI = 32'd201223;
  localparam logic [31:0] WIN_DO_LO = HALF_DO + HALF_RI;
  localparam logic [31:0] WIN_RI_LO = HALF_RI + HALF_MI;
  localparam logic [31:0] WIN_MI_LO = HALF_MI + HALF_FA;
  localparam logic [31:0] WIN_FA_LO = HALF_FA + HALF_SO;
  localparam logic [31:0] WIN_SO_LO = HALF_SO + HALF_LA;
  localparam logic [31:0] WIN_LA_LO = HALF_LA + HALF_XI;
  localparam logic [31:0] WIN_XI_LO = 32'd95003;

  // Detector FSM: IDLE has no reference edge yet, MEAS is timing a period
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } detState_t;

  // Windows are inclusive low / exclusive high. 'shift' divides every bound
  // by a power of two so the same table serves a prescaled sample clock;
  // shift = 0 gives the 50 MHz windows.
  function automatic logic [2:0] classifyPeriod(input logic [31:0] per,
                                                input int unsigned shift);
    logic [2:0] cls;
    cls = NOTE_IDLE;
    if (per >= (WIN_DO_HI >> shift))      cls = NOTE_IDLE;
    else if (per >= (WIN_DO_LO >> shift)) cls = NOTE_DO;
    else if (per >= (WIN_RI_LO >> shift)) cls = NOTE_RI;
    else if (per >= (WIN_MI_LO >> shift)) cls = NOTE_MI;
    else if (per >= (WIN_FA_LO >> shift)) cls = NOTE_FA;
    else if (per >= (WIN_SO_LO >> shift)) cls = NOTE_SO;
    else if (per >= (WIN_LA_LO >> shift)) cls = NOTE_LA;
    else if (per >= (WIN_XI_LO >> shift)) cls = NOTE_XI;
    return cls;
  endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// -----------------------------------------------------------------------------
// tone_sync_edge
// Brings the asynchronous tone input into the clk domain through a 2-flop
// synchronizer and produces a registered one-cycle pulse on each rising edge.
// The pulse appears 3 clk after the tone edge.
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   tone_i  asynchronous square-wave input
//   rise_o  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module tone_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tone_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;
  logic rise_d;

  assign rise_d = sync2_q & ~prev_q;

  // Synchronizer chain, previous-value flop and registered edge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= tone_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/tone_note_detect.sv
// -----------------------------------------------------------------------------
// tone_note_detect
// Measures the period of an asynchronous square-wave tone in clk cycles,
// classifies it as one of the seven scale notes and reports the note once
// STABLE_CNT consecutive periods agree. The note is dropped when no rising
// edge arrives for TIMEOUT cycles or when an out-of-window period is seen.
// Ports:
//   clk          system clock (50 MHz)
//   rst          asynchronous active-low reset
//   tone_in      asynchronous square-wave tone
//   note         detected note, 0 = none, 1..7 = Do..Xi
//   note_valid   high while note is non-zero and locked
//   note_strobe  one-cycle pulse on every change of note (including to 0)
//   period       last measured period in cycles
// Parameters:
//   STABLE_CNT   consecutive same-class periods needed to lock (1..7)
//   TIMEOUT      edge-free cycles before the note is dropped
//   CNT_W        period counter width
//   WIN_SHIFT    right shift applied to the class windows (0 at 50 MHz)
// -----------------------------------------------------------------------------
module tone_note_detect
  import beep_note_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 250000,
  parameter int unsigned CNT_W      = 18,
  parameter int unsigned WIN_SHIFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [2:0]       note,
  output logic             note_valid,
  output logic             note_strobe,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [2:0]       STABLE_C  = 3'(STABLE_CNT);

  logic             rise;
  logic             timeout;
  logic             sameClass;
  logic [CNT_W-1:0] measPeriod;
  logic [2:0]       measClass;

  detState_t        state_q,     state_d;
  logic [CNT_W-1:0] perCnt_q,    perCnt_d;
  logic [2:0]       stable_q,    stable_d;
  logic [2:0]       prevClass_q, prevClass_d;
  logic [2:0]       note_q,      note_d;
  logic             valid_q,     valid_d;
  logic             strobe_q,    strobe_d;
  logic [CNT_W-1:0] period_q,    period_d;

  tone_sync_edge uSyncEdge (
    .clk    (clk),
    .rst    (rst),
    .tone_i (tone_in),
    .rise_o (rise)
  );

  // The counter was cleared in the previous rise cycle, so the cycles since
  // that rise are one more than its current value.
  assign measPeriod = perCnt_q + CNT_W'(1);
  assign measClass  = classifyPeriod(32'(measPeriod), WIN_SHIFT);
  assign sameClass  = (measClass == prevClass_q) && (measClass != NOTE_IDLE);
  assign timeout    = (state_q == ST_MEAS) && (perCnt_q == TIMEOUT_C);

  // Next-state logic. A rise coinciding with a timeout is handled as the
  // timeout first, then the rise re-arms the measurement without latching.
  always_comb begin
    state_d     = state_q;
    perCnt_d    = perCnt_q;
    stable_d    = stable_q;
    prevClass_d = prevClass_q;
    note_d      = note_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    period_d    = period_q;

    if (rise) begin
      perCnt_d = '0;
    end else if (perCnt_q != TIMEOUT_C) begin
      perCnt_d = perCnt_q + CNT_W'(1);
    end

    if (timeout) begin
      state_d     = rise ? ST_MEAS : ST_IDLE;
      stable_d    = 3'd0;
      prevClass_d = NOTE_IDLE;
      if (note_q != NOTE_IDLE) begin
        note_d   = NOTE_IDLE;
        valid_d  = 1'b0;
        strobe_d = 1'b1;
      end
    end else if (rise) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_MEAS;
      end else begin
        period_d    = measPeriod;
        prevClass_d = measClass;
        if (sameClass) begin
          stable_d = (stable_q < STABLE_C) ? stable_q + 3'd1 : stable_q;
        end else begin
          stable_d = (measClass != NOTE_IDLE) ? 3'd1 : 3'd0;
        end

        if (measClass == NOTE_IDLE) begin
          if (note_q != NOTE_IDLE) begin
            note_d   = NOTE_IDLE;
            valid_d  = 1'b0;
            strobe_d = 1'b1;
          end
        end else if ((stable_d == STABLE_C) && (measClass != note_q)) begin
          note_d   = measClass;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      perCnt_q    <= '0;
      stable_q    <= 3'd0;
      prevClass_q <= NOTE_IDLE;
      note_q      <= NOTE_IDLE;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      perCnt_q    <= perCnt_d;
      stable_q    <= stable_d;
      prevClass_q <= prevClass_d;
      note_q      <= note_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      period_q    <= period_d;
    end
  end

  assign note        = note_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;
  assign period      = period_q;

endmodule

// File: tb/tb_tone_note_detect.sv
// -----------------------------------------------------------------------------
// tb_tone_note_detect
// Self-checking bench for tone_note_detect. The class windows are scaled by
// 2^8 so full lock/timeout sequences stay short; the unscaled window bounds
// are checked directly through the package classifier.
// Scaled windows (bound >> 8): Xi 371, La 419, So 471, Fa 528, Mi 575,
// Ri 628, Do 704, upper 786.
// -----------------------------------------------------------------------------
module tb_tone_note_detect;
  import beep_note_pkg::*;

  localparam int unsigned TB_SHIFT   = 8;
  localparam int unsigned TB_TIMEOUT = 1000;
  localparam int unsigned TB_CNT_W   = 18;
  localparam int          MAX_PER    = 800;

  typedef struct {
    logic [31:0] per;
    int unsigned shift;
    logic [2:0]  expNote;
  } classVec_t;

  logic                clk;
  logic                rst;
  logic                tone_in;
  logic [2:0]          note;
  logic                note_valid;
  logic                note_strobe;
  logic [TB_CNT_W-1:0] period;

  int  compared;
  int  mismatched;
  int  toneRises;
  int  strobeCount;
  int  strobeBase;
  int  periodA;
  int  periodB;
  bit  toneRun;

  classVec_t classVecs[23];
  int        sweepPer[7];

  tone_note_detect #(
    .STABLE_CNT (2),
    .TIMEOUT    (TB_TIMEOUT),
    .CNT_W      (TB_CNT_W),
    .WIN_SHIFT  (TB_SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .note        (note),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .period      (period)
  );

  // 100 MHz simulation clock; only cycle counts matter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses, sampled on the inactive edge
  initial strobeCount = 0;
  always @(negedge clk) begin
    if (note_strobe === 1'b1) strobeCount++;
  end

  // Tone generator: rises on the first negedge of each period, high for half
  // of it. A new period setting takes effect at the next rising edge; when
  // periodA != periodB the two alternate.
  initial begin
    int  phase;
    int  curPer;
    bit  useB;
    tone_in   = 1'b0;
    toneRises = 0;
    phase     = 0;
    curPer    = 2;
    useB      = 1'b0;
    forever begin
      @(negedge clk);
      if (!toneRun) begin
        tone_in = 1'b0;
        phase   = 0;
        useB    = 1'b0;
      end else begin
        if (phase == 0) begin
          curPer  = useB ? periodB : periodA;
          tone_in = 1'b1;
          toneRises++;
        end else if (phase == curPer / 2) begin
          tone_in = 1'b0;
        end
        phase++;
        if (phase >= curPer) begin
          phase = 0;
          useB  = ~useB;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int pa, input int pb, input bit run);
    periodA = pa;
    periodB = pb;
    toneRun = run;
  endtask

  task automatic applyReset();
    toneRun = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    strobeBase = strobeCount;
  endtask

  // Returns on the first posedge after the n-th further tone rising edge
  task automatic waitRises(input int n, input string name);
    int  target;
    bit  hit;
    target = toneRises + n;
    hit    = 1'b0;
    for (int i = 0; i < n * MAX_PER + 100; i++) begin
      @(posedge clk);
      if (toneRises >= target) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(hit), 32'd1);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    strobeBase = 0;
    toneRun    = 1'b0;
    periodA    = 746;
    periodB    = 746;

    // Unscaled window edges plus a few scaled ones
    classVecs[0]  = '{32'd0,      0, 3'd0};
    classVecs[1]  = '{32'd95002,  0, 3'd0};
    classVecs[2]  = '{32'd95003,  0, 3'd7};
    classVecs[3]  = '{32'd107424, 0, 3'd7};
    classVecs[4]  = '{32'd107425, 0, 3'd6};
    classVecs[5]  = '{32'd120592, 0, 3'd6};
    classVecs[6]  = '{32'd120593, 0, 3'd5};
    classVecs[7]  = '{32'd135407, 0, 3'd5};
    classVecs[8]  = '{32'd135408, 0, 3'd4};
    classVecs[9]  = '{32'd147389, 0, 3'd4};
    classVecs[10] = '{32'd147390, 0, 3'd3};
    classVecs[11] = '{32'd160790, 0, 3'd3};
    classVecs[12] = '{32'd160791, 0, 3'd2};
    classVecs[13] = '{32'd180452, 0, 3'd2};
    classVecs[14] = '{32'd180453, 0, 3'd1};
    classVecs[15] = '{32'd201222, 0, 3'd1};
    classVecs[16] = '{32'd201223, 0, 3'd0};
    classVecs[17] = '{32'd785,    8, 3'd1};
    classVecs[18] = '{32'd786,    8, 3'd0};
    classVecs[19] = '{32'd703,    8, 3'd2};
    classVecs[20] = '{32'd704,    8, 3'd1};
    classVecs[21] = '{32'd370,    8, 3'd0};
    classVecs[22] = '{32'd371,    8, 3'd7};

    // Scaled full periods Do..Xi, each inside its scaled window
    sweepPer = '{746, 664, 592, 560, 498, 444, 396};

    // Reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset note",   32'(note),        32'd0);
    checkOutput("reset valid",  32'(note_valid),  32'd0);
    checkOutput("reset strobe", 32'(note_strobe), 32'd0);
    checkOutput("reset period", 32'(period),      32'd0);

    // Classification table
    for (int i = 0; i < 23; i++) begin
      checkOutput($sformatf("class[%0d] per=%0d", i, classVecs[i].per),
                  32'(classifyPeriod(classVecs[i].per, classVecs[i].shift)),
                  32'(classVecs[i].expNote));
    end

    // Do from reset: locks exactly 4 clk after the third rising edge
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    strobeBase = strobeCount;
    applyStimulus(746, 746, 1'b1);
    waitRises(3, "do wait");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("do pre-lock note", 32'(note), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("do lock note",   32'(note),        32'd1);
    checkOutput("do lock valid",  32'(note_valid),  32'd1);
    checkOutput("do lock strobe", 32'(note_strobe), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("do strobe width", 32'(note_strobe), 32'd0);
    waitRises(2, "do hold wait");
    settle();
    checkOutput("do period",  32'(period), 32'd746);
    checkOutput("do note",    32'(note),   32'd1);
    checkOutput("do strobes", 32'(strobeCount - strobeBase), 32'd1);

    // Full scale sweep, then the tone stops and the note times out
    applyReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(sweepPer[i], sweepPer[i], 1'b1);
      waitRises(3, "sweep wait");
      settle();
      checkOutput($sformatf("sweep note %0d", i + 1), 32'(note), 32'(i + 1));
    end
    checkOutput("sweep strobes", 32'(strobeCount - strobeBase), 32'd7);
    applyStimulus(396, 396, 1'b0);
    repeat (TB_TIMEOUT + 200) @(posedge clk);
    #1;
    checkOutput("sweep end note",    32'(note),       32'd0);
    checkOutput("sweep end valid",   32'(note_valid), 32'd0);
    checkOutput("sweep end strobes", 32'(strobeCount - strobeBase), 32'd8);

    // Period below every window: never locks, period still reported
    applyReset();
    applyStimulus(352, 352, 1'b1);
    waitRises(5, "fast wait");
    settle();
    checkOutput("fast note",    32'(note),       32'd0);
    checkOutput("fast valid",   32'(note_valid), 32'd0);
    checkOutput("fast strobes", 32'(strobeCount - strobeBase), 32'd0);
    checkOutput("fast period",  32'(period),     32'd352);

    // Lock on La, then alternate La/Mi: Mi never gets two in a row
    applyReset();
    applyStimulus(444, 444, 1'b1);
    waitRises(3, "la wait");
    settle();
    checkOutput("la lock note", 32'(note), 32'd6);
    applyStimulus(592, 444, 1'b1);
    waitRises(6, "alt wait");
    settle();
    checkOutput("alt note",    32'(note),       32'd6);
    checkOutput("alt valid",   32'(note_valid), 32'd1);
    checkOutput("alt strobes", 32'(strobeCount - strobeBase), 32'd1);

    // Lock on Xi, stop after one more edge: drop exactly TIMEOUT+5 clk later
    applyReset();
    applyStimulus(396, 396, 1'b1);
    waitRises(3, "xi wait");
    settle();
    checkOutput("xi lock note", 32'(note), 32'd7);
    waitRises(1, "xi last edge");
    toneRun = 1'b0;
    repeat (TB_TIMEOUT + 3) @(posedge clk);
    #1;
    checkOutput("xi pre-timeout note",   32'(note),        32'd7);
    checkOutput("xi pre-timeout strobe", 32'(note_strobe), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("xi timeout note",   32'(note),        32'd0);
    checkOutput("xi timeout valid",  32'(note_valid),  32'd0);
    checkOutput("xi timeout strobe", 32'(note_strobe), 32'd1);

    // Reset in the middle of a So lock, then relock within three edges
    applyReset();
    applyStimulus(498, 498, 1'b1);
    waitRises(3, "so wait");
    settle();
    checkOutput("so lock note", 32'(note), 32'd5);
    repeat (100) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("so rst note",   32'(note),        32'd0);
    checkOutput("so rst valid",  32'(note_valid),  32'd0);
    checkOutput("so rst strobe", 32'(note_strobe), 32'd0);
    checkOutput("so rst period", 32'(period),      32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    strobeBase = strobeCount;
    waitRises(3, "so relock wait");
    settle();
    checkOutput("so relock note",    32'(note),       32'd5);
    checkOutput("so relock valid",   32'(note_valid), 32'd1);
    checkOutput("so relock strobes", 32'(strobeCount - strobeBase), 32'd1);

    toneRun = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
